// File: rtl/mips_multicycle_core.sv
// Multi-cycle 16-bit-instruction core: FETCH/DECODE/EXEC/MEM/WB FSM with req/ack
// instruction and data memory ports, hardwired-zero r0 and an absorbing HALT state.
module mips_multicycle_core #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 6,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              clear,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [PC_W-1:0]   pc,
    output logic              instr_done,
    output logic              halted,
    output logic [DATA_W-1:0] dbg_a,
    output logic [DATA_W-1:0] dbg_b,
    output logic [DATA_W-1:0] dbg_wdata
);
    localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4, OP_ADDI = 4'h5, OP_LW = 4'h6, OP_SW  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8, OP_BNE = 4'h9, OP_JMP = 4'hA, OP_HALT = 4'hF;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            state_q, state_d;
    logic              idle_q;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic [3:0]        op, imm4;
    logic [RI_W-1:0]   rsIdx, rtIdx, rdIdx, destIdx;
    logic [DATA_W-1:0] rfA, rfB, immZ, aluRes, wbData;
    logic [PC_W-1:0]   immS;
    logic              isIllegal, branchTaken, sltBit, regWe;

    assign op        = ir_q[15:12];
    assign rsIdx     = ir_q[8 +: RI_W];
    assign rtIdx     = ir_q[4 +: RI_W];
    assign rdIdx     = ir_q[0 +: RI_W];
    assign imm4      = ir_q[3:0];
    assign immZ      = {{(DATA_W-4){1'b0}}, imm4};
    assign immS      = {{(PC_W-4){imm4[3]}}, imm4};
    assign isIllegal = (op >= 4'hB) && (op <= 4'hE);
    assign rfA       = (rsIdx == '0) ? '0 : regs_q[rsIdx];
    assign rfB       = (rtIdx == '0) ? '0 : regs_q[rtIdx];
    assign sltBit    = $signed(a_q) < $signed(b_q);
    assign branchTaken = ((op == OP_BEQ) && (a_q == b_q)) || ((op == OP_BNE) && (a_q != b_q));
    assign destIdx   = (op <= OP_SLT) ? rdIdx : rtIdx;
    assign wbData    = (op == OP_LW) ? mdr_q : alu_q;

    always_comb begin
        aluRes = '0;
        case (op)
            OP_ADD:                 aluRes = a_q + b_q;
            OP_SUB:                 aluRes = a_q - b_q;
            OP_AND:                 aluRes = a_q & b_q;
            OP_OR:                  aluRes = a_q | b_q;
            OP_SLT:                 aluRes = {{(DATA_W-1){1'b0}}, sltBit};
            OP_ADDI, OP_LW, OP_SW:  aluRes = a_q + immZ;
            default:                aluRes = '0;
        endcase
    end

    // idle_q masks the first cycle after clear so req stays low and a late ack is dropped
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_FETCH;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idle_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (!idle_q && imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = isIllegal ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (op <= OP_ADDI)                      state_d = S_WB;
                else if (op == OP_LW || op == OP_SW)    state_d = S_MEM;
                else if (op == OP_HALT)                 state_d = S_HALT;
                else                                    state_d = S_FETCH;
            end
            S_MEM:    if (dmem_ack) state_d = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == S_FETCH) && !idle_q;
        dmem_req   = (state_q == S_MEM);
        dmem_we    = (state_q == S_MEM) && (op == OP_SW);
        halted     = (state_q == S_HALT);
        regWe      = (state_q == S_WB);
        instr_done = 1'b0;
        case (state_q)
            S_DECODE: instr_done = isIllegal;
            S_EXEC:   instr_done = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP) || (op == OP_HALT);
            S_MEM:    instr_done = dmem_ack && (op == OP_SW);
            S_WB:     instr_done = 1'b1;
            default:  instr_done = 1'b0;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        a_d   = a_q;
        b_d   = b_q;
        alu_d = alu_q;
        mdr_d = mdr_q;
        case (state_q)
            S_FETCH: begin
                if (!idle_q && imem_ack) begin
                    ir_d = imem_rdata;
                    pc_d = pc_q + PC_W'(1);
                end
            end
            S_DECODE: begin
                a_d = rfA;
                b_d = rfB;
            end
            S_EXEC: begin
                alu_d = aluRes;
                // pc already points past the branch, so the offset is relative to pc+1
                if (branchTaken)       pc_d = pc_q + immS;
                else if (op == OP_JMP) pc_d = ir_q[PC_W-1:0];
            end
            S_MEM:   if (dmem_ack && op == OP_LW) mdr_d = dmem_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            alu_q <= alu_d;
            mdr_q <= mdr_d;
            if (regWe && destIdx != '0) regs_q[destIdx] <= wbData;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;
    assign dbg_a      = rfA;
    assign dbg_b      = rfB;
    assign dbg_wdata  = wbData;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: directed programs push expected retirements,
// a monitor pops them on each instr_done and checks write data, store bus, latency and next pc.
module tb_mips_multicycle_core;
    localparam int DATA_W = 16;
    localparam int PC_W   = 6;
    localparam int NREGS  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              clear;
    logic              imem_req, imem_ack;
    logic [PC_W-1:0]   imem_addr, pc;
    logic [15:0]       imem_rdata;
    logic              dmem_req, dmem_we, dmem_ack;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic              instr_done, halted;
    logic [DATA_W-1:0] dbg_a, dbg_b, dbg_wdata;

    mips_multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS)) dut (
        .clk(clk), .clear(clear),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pc(pc), .instr_done(instr_done), .halted(halted),
        .dbg_a(dbg_a), .dbg_b(dbg_b), .dbg_wdata(dbg_wdata)
    );

    // Memory responders with programmable wait states
    logic [15:0] imem [64];
    logic [15:0] dmem [64];
    int  imemDelay = 0, dmemDelay = 0, imemWait = 0, dmemWait = 0;
    bit  forceImemAck = 1'b0;

    assign imem_ack   = (imem_req && (imemWait >= imemDelay)) || forceImemAck;
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = dmem_req && (dmemWait >= dmemDelay);
    assign dmem_rdata = dmem[dmem_addr[5:0]];

    always @(posedge clk) begin
        if (imem_req && !imem_ack) imemWait <= imemWait + 1; else imemWait <= 0;
        if (dmem_req && !dmem_ack) dmemWait <= dmemWait + 1; else dmemWait <= 0;
        if (dmem_req && dmem_we && dmem_ack) dmem[dmem_addr[5:0]] <= dmem_wdata;
    end

    typedef struct {
        string       name;
        bit          chkW;
        logic [15:0] w;
        bit          chkM;
        logic [15:0] addr;
        logic [15:0] mw;
        int          cyc;
        logic [5:0]  pcN;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          compared = 0, mismatched = 0, cnt = 0;
    bit          pendPc = 1'b0;
    logic [5:0]  expPc;
    string       pendName;

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [3:0] rd);
        return {op, rs, rt, rd};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input string name, input bit chkW, input logic [15:0] w, input bit chkM,
                           input logic [15:0] addr, input logic [15:0] mw, input int cyc,
                           input logic [5:0] pcN);
        exp_t x;
        x.name = name; x.chkW = chkW; x.w = w; x.chkM = chkM;
        x.addr = addr; x.mw = mw; x.cyc = cyc; x.pcN = pcN;
        sb.push_back(x);
    endtask

    // Monitor: latency counts cycles since the previous retirement (or since clear released)
    always @(posedge clk) begin
        #1;
        if (clear) begin
            cnt    = 0;
            pendPc = 1'b0;
        end else begin
            cnt++;
            if (pendPc) begin
                checkOutput({pendName, " next pc"}, 32'(pc), 32'(expPc));
                pendPc = 1'b0;
            end
            if (instr_done) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected retire: got pc %0h expected no retirement", pc);
                end else begin
                    e = sb.pop_front();
                    if (e.chkW) checkOutput({e.name, " wdata"}, 32'(dbg_wdata), 32'(e.w));
                    if (e.chkM) begin
                        checkOutput({e.name, " dmem_we"},    32'(dmem_we),    32'd1);
                        checkOutput({e.name, " dmem_addr"},  32'(dmem_addr),  32'(e.addr));
                        checkOutput({e.name, " dmem_wdata"}, 32'(dmem_wdata), 32'(e.mw));
                    end
                    checkOutput({e.name, " cycles"}, 32'(cnt), 32'(e.cyc));
                    pendPc   = 1'b1;
                    expPc    = e.pcN;
                    pendName = e.name;
                    cnt      = 0;
                end
            end
        end
    end

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || pendPc) && n < budget) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (sb.size() != 0 || pendPc) begin
            mismatched++;
            $display("[TB] FAIL %s timeout: got %0d retirements pending expected 0", name, sb.size());
            sb.delete();
            pendPc = 1'b0;
        end
    endtask

    task automatic loadBlank();
        for (int i = 0; i < 64; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = 16'h0000;
        end
    endtask

    task automatic applyStimulus(input int scen);
        int reqSeen;
        case (scen)
            // clear during a stalled fetch, with a stray ack held through the masked cycle
            0: begin
                clear = 1'b1; imemDelay = 1000; dmemDelay = 0; forceImemAck = 1'b0;
                loadBlank();
                repeat (2) @(negedge clk);
                clear = 1'b0;
                repeat (3) @(negedge clk);
                checkOutput("stalled fetch req", 32'(imem_req), 32'd1);
                checkOutput("stalled fetch pc",  32'(pc),       32'd0);
                clear = 1'b1; forceImemAck = 1'b1;
                @(negedge clk);
                checkOutput("clear1 req",    32'(imem_req), 32'd0);
                checkOutput("clear1 pc",     32'(pc),       32'd0);
                checkOutput("clear1 halted", 32'(halted),   32'd0);
                @(negedge clk);
                checkOutput("clear2 req",    32'(imem_req), 32'd0);
                checkOutput("clear2 halted", 32'(halted),   32'd0);
                clear = 1'b0;
                @(negedge clk);
                checkOutput("late ack ignored req", 32'(imem_req), 32'd1);
                checkOutput("late ack ignored pc",  32'(pc),       32'd0);
                forceImemAck = 1'b0;
            end
            // arithmetic, delayed store/load, HALT at pc 7
            1: begin
                @(negedge clk);
                clear = 1'b1; imemDelay = 0; dmemDelay = 3;
                loadBlank();
                imem[0] = enc(4'h5, 4'h0, 4'h1, 4'h5);
                imem[1] = enc(4'h5, 4'h0, 4'h2, 4'h3);
                imem[2] = enc(4'h1, 4'h1, 4'h2, 4'h3);
                imem[3] = enc(4'h4, 4'h2, 4'h1, 4'h4);
                imem[4] = enc(4'h7, 4'h0, 4'h3, 4'h4);
                imem[5] = enc(4'h6, 4'h0, 4'h5, 4'h4);
                imem[6] = enc(4'h1, 4'h2, 4'h1, 4'h6);
                imem[7] = enc(4'hF, 4'h0, 4'h0, 4'h0);
                pushExp("ADDI r1=5",  1, 16'd5,      0, 0, 0,     4, 6'd1);
                pushExp("ADDI r2=3",  1, 16'd3,      0, 0, 0,     4, 6'd2);
                pushExp("SUB r3",     1, 16'd2,      0, 0, 0,     4, 6'd3);
                pushExp("SLT r4",     1, 16'd1,      0, 0, 0,     4, 6'd4);
                pushExp("SW r3",      0, 0,          1, 16'd4, 16'd2, 7, 6'd5);
                pushExp("LW r5",      1, 16'd2,      0, 0, 0,     8, 6'd6);
                pushExp("SUB wrap",   1, 16'hFFFE,   0, 0, 0,     4, 6'd7);
                pushExp("HALT",       0, 0,          0, 0, 0,     3, 6'd8);
                @(negedge clk);
                clear = 1'b0;
                waitDrain("program A", 400);
                checkOutput("halted flag", 32'(halted), 32'd1);
                checkOutput("stored word", 32'(dmem[4]), 32'd2);
                reqSeen = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (imem_req) reqSeen++;
                end
                checkOutput("no fetch after halt", 32'(reqSeen), 32'd0);
                checkOutput("pc frozen in halt",   32'(pc),      32'd8);
            end
            // r0 write discard, BNE loop, illegal op, JMP, fetch wrap at 63
            2: begin
                @(negedge clk);
                clear = 1'b1; imemDelay = 0; dmemDelay = 0;
                loadBlank();
                imem[0]  = enc(4'h5, 4'h0, 4'h1, 4'h5);
                imem[1]  = enc(4'h5, 4'h0, 4'h2, 4'h3);
                imem[2]  = enc(4'h0, 4'h1, 4'h2, 4'h0);
                imem[3]  = enc(4'h0, 4'h0, 4'h1, 4'h7);
                imem[4]  = enc(4'h5, 4'h0, 4'h6, 4'h1);
                imem[5]  = enc(4'h5, 4'h0, 4'h1, 4'h3);
                imem[6]  = enc(4'h1, 4'h1, 4'h6, 4'h1);
                imem[7]  = enc(4'h9, 4'h1, 4'h0, 4'hE);
                imem[8]  = 16'hC000;
                imem[9]  = enc(4'hA, 4'h0, 4'h3, 4'hE);
                imem[62] = enc(4'h5, 4'h7, 4'h8, 4'h4);
                imem[63] = enc(4'hF, 4'h0, 4'h0, 4'h0);
                pushExp("B ADDI r1=5",  1, 16'd5, 0, 0, 0, 4, 6'd1);
                pushExp("B ADDI r2=3",  1, 16'd3, 0, 0, 0, 4, 6'd2);
                pushExp("ADD r0",       1, 16'd8, 0, 0, 0, 4, 6'd3);
                pushExp("ADD r7=r0+r1", 1, 16'd5, 0, 0, 0, 4, 6'd4);
                pushExp("ADDI r6=1",    1, 16'd1, 0, 0, 0, 4, 6'd5);
                pushExp("ADDI r1=3",    1, 16'd3, 0, 0, 0, 4, 6'd6);
                pushExp("loop1 SUB",    1, 16'd2, 0, 0, 0, 4, 6'd7);
                pushExp("loop1 BNE",    0, 0,     0, 0, 0, 3, 6'd6);
                pushExp("loop2 SUB",    1, 16'd1, 0, 0, 0, 4, 6'd7);
                pushExp("loop2 BNE",    0, 0,     0, 0, 0, 3, 6'd6);
                pushExp("loop3 SUB",    1, 16'd0, 0, 0, 0, 4, 6'd7);
                pushExp("loop3 BNE",    0, 0,     0, 0, 0, 3, 6'd8);
                pushExp("illegal op",   0, 0,     0, 0, 0, 2, 6'd9);
                pushExp("JMP 62",       0, 0,     0, 0, 0, 3, 6'd62);
                pushExp("ADDI r8",      1, 16'd9, 0, 0, 0, 4, 6'd63);
                pushExp("HALT at 63",   0, 0,     0, 0, 0, 3, 6'd0);
                @(negedge clk);
                clear = 1'b0;
                waitDrain("program B", 600);
                checkOutput("halted after B", 32'(halted), 32'd1);
            end
            // negative branch offset from pc 0 wraps to 63, then fetch wraps back to 0
            default: begin
                @(negedge clk);
                clear = 1'b1; imemDelay = 1; dmemDelay = 0;
                loadBlank();
                imem[0]  = enc(4'h8, 4'h0, 4'h0, 4'hE);
                imem[63] = enc(4'h5, 4'h0, 4'h1, 4'h7);
                pushExp("BEQ wrap",     0, 0,     0, 0, 0, 4, 6'd63);
                pushExp("ADDI at 63",   1, 16'd7, 0, 0, 0, 5, 6'd0);
                pushExp("BEQ wrap 2",   0, 0,     0, 0, 0, 4, 6'd63);
                @(negedge clk);
                clear = 1'b0;
                waitDrain("program C", 300);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end
        endcase
    endtask

    initial begin
        clear = 1'b1;
        for (int s = 0; s < 4; s++) applyStimulus(s);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
